// File: rtl/instr_retire_monitor_if.sv
// Observation bus between the TCES330 control unit and the retire monitor,
// plus the record drain port used by a debug reader or testbench.
interface instr_retire_monitor_if #(
  parameter int unsigned CNT_W = 16
);
  logic             PC_clr;
  logic             IR_ld;
  logic             PC_up;
  logic             D_wr;
  logic             RF_s;
  logic             RF_W_en;
  logic [7:0]       D_addr;
  logic [3:0]       RF_W_addr;
  logic [3:0]       RF_Ra_addr;
  logic [3:0]       RF_Rb_addr;
  logic [2:0]       Alu_s0;
  logic             Rec_rd;
  logic             Rec_valid;
  logic [15:0]      Rec_data;
  logic [CNT_W-1:0] Retire_count;
  logic             Halted;
  logic             Proto_err;
  logic             Overflow;

  // Control-unit / reader side
  modport master (
    output PC_clr, IR_ld, PC_up, D_wr, RF_s, RF_W_en,
    output D_addr, RF_W_addr, RF_Ra_addr, RF_Rb_addr, Alu_s0,
    output Rec_rd,
    input  Rec_valid, Rec_data, Retire_count, Halted, Proto_err, Overflow
  );

  // Monitor side
  modport slave (
    input  PC_clr, IR_ld, PC_up, D_wr, RF_s, RF_W_en,
    input  D_addr, RF_W_addr, RF_Ra_addr, RF_Rb_addr, Alu_s0,
    input  Rec_rd,
    output Rec_valid, Rec_data, Retire_count, Halted, Proto_err, Overflow
  );
endinterface

// File: rtl/instr_retire_monitor.sv
// Passive retire monitor: follows the control-unit strobe sequence, rebuilds each
// retired instruction's 16-bit IR word and queues it in a small drainable FIFO.
module instr_retire_monitor #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 Clk,
  input  logic                 ResetN,
  instr_retire_monitor_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DEC    = 3'd1,
    S_EXE    = 3'd2,
    S_Z1     = 3'd3,
    S_HALTED = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  state_t           r_state;
  logic [15:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [OCC_W-1:0] r_occ;
  logic             r_rec_valid;
  logic [15:0]      r_rec_data;
  logic [CNT_W-1:0] r_count;
  logic             r_halted;
  logic             r_proto_err;
  logic             r_overflow;

  logic             w_act;
  logic             w_zero;
  logic             w_fetch;
  logic             w_alu_pat;
  state_t           w_next;
  logic             w_retire;
  logic [15:0]      w_word;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic [OCC_W-1:0] w_occ_next;
  logic [PTR_W-1:0] w_rd_ptr_next;
  logic [15:0]      w_head_next;

  // Strobe classification of the current cycle
  always_comb begin
    w_act     = bus.PC_clr | bus.IR_ld | bus.PC_up | bus.D_wr | bus.RF_s | bus.RF_W_en;
    w_zero    = ~w_act;
    w_fetch   = bus.IR_ld & bus.PC_up & ~bus.PC_clr & ~bus.D_wr & ~bus.RF_s & ~bus.RF_W_en;
    w_alu_pat = bus.RF_W_en & ~bus.RF_s & ~bus.D_wr;
  end

  // Sequence tracking and IR word reconstruction
  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    w_word   = '0;
    case (r_state)
      S_IDLE: begin
        if (bus.PC_clr || w_zero) w_next = S_IDLE;
        else if (w_fetch)         w_next = S_DEC;
        else                      w_next = S_ERR;
      end
      S_DEC: begin
        w_next = w_zero ? S_EXE : S_ERR;
      end
      S_EXE: begin
        if (bus.D_wr && !bus.RF_W_en && !bus.RF_s) begin
          w_retire = 1'b1;
          w_word   = {4'h1, bus.RF_Ra_addr, bus.D_addr};
          w_next   = S_IDLE;
        end else if (w_alu_pat && bus.Alu_s0 == 3'd1) begin
          w_retire = 1'b1;
          w_word   = {4'h3, bus.RF_Ra_addr, bus.RF_Rb_addr, bus.RF_W_addr};
          w_next   = S_IDLE;
        end else if (w_alu_pat && bus.Alu_s0 == 3'd2) begin
          w_retire = 1'b1;
          w_word   = {4'h4, bus.RF_Ra_addr, bus.RF_Rb_addr, bus.RF_W_addr};
          w_next   = S_IDLE;
        end else if (w_zero) begin
          w_next = S_Z1;
        end else begin
          w_next = S_ERR;
        end
      end
      S_Z1: begin
        // A fetch here means the previous instruction was a Noop
        if (w_fetch) begin
          w_retire = 1'b1;
          w_word   = 16'h0000;
          w_next   = S_DEC;
        end else if (bus.RF_s && bus.RF_W_en && !bus.D_wr) begin
          w_retire = 1'b1;
          w_word   = {4'h2, bus.D_addr, bus.RF_W_addr};
          w_next   = S_IDLE;
        end else if (w_zero) begin
          w_retire = 1'b1;
          w_word   = 16'h5000;
          w_next   = S_HALTED;
        end else if (bus.PC_clr) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_ERR;
        end
      end
      S_HALTED: begin
        if (w_zero)          w_next = S_HALTED;
        else if (bus.PC_clr) w_next = S_IDLE;
        else                 w_next = S_ERR;
      end
      S_ERR: begin
        w_next = bus.PC_clr ? S_IDLE : S_ERR;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // FIFO bookkeeping; a pop on a full FIFO frees the slot for a same-cycle push
  always_comb begin
    w_full        = (r_occ == OCC_W'(DEPTH));
    w_pop         = bus.Rec_rd && (r_occ != '0);
    w_push        = w_retire && (!w_full || w_pop);
    w_occ_next    = r_occ + OCC_W'(w_push) - OCC_W'(w_pop);
    w_rd_ptr_next = r_rd_ptr + PTR_W'(w_pop);
    if (w_occ_next == '0)
      w_head_next = '0;
    else if (r_occ == '0 || (w_pop && r_occ == OCC_W'(1)))
      w_head_next = w_word;
    else
      w_head_next = r_mem[w_rd_ptr_next];
  end

  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      r_state     <= S_IDLE;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_occ       <= '0;
      r_rec_valid <= 1'b0;
      r_rec_data  <= '0;
      r_count     <= '0;
      r_halted    <= 1'b0;
      r_proto_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_halted    <= (w_next == S_HALTED);
      if (w_next == S_ERR) r_proto_err <= 1'b1;
      if (w_retire) r_count <= r_count + CNT_W'(1);
      if (w_retire && w_full && !w_pop) r_overflow <= 1'b1;
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_word;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      r_rd_ptr    <= w_rd_ptr_next;
      r_occ       <= w_occ_next;
      r_rec_valid <= (w_occ_next != '0);
      r_rec_data  <= w_head_next;
    end
  end

  assign bus.Rec_valid    = r_rec_valid;
  assign bus.Rec_data     = r_rec_data;
  assign bus.Retire_count = r_count;
  assign bus.Halted       = r_halted;
  assign bus.Proto_err    = r_proto_err;
  assign bus.Overflow     = r_overflow;

endmodule

// File: tb/tb_instr_retire_monitor.sv
// Directed bench for instr_retire_monitor: drives control-unit strobe sequences
// and checks the reconstructed records, counter and flags.
module tb_instr_retire_monitor;

  localparam logic [5:0] S_ZERO  = 6'b000000;
  localparam logic [5:0] S_CLR   = 6'b100000;
  localparam logic [5:0] S_FETCH = 6'b011000;
  localparam logic [5:0] S_DWR   = 6'b000100;
  localparam logic [5:0] S_WEN   = 6'b000001;
  localparam logic [5:0] S_LDB   = 6'b000011;

  logic Clk = 1'b0;
  logic ResetN;
  int   total = 0;
  int   bad   = 0;

  always #5 Clk = ~Clk;

  instr_retire_monitor_if #(.CNT_W(16)) bus ();

  instr_retire_monitor #(.DEPTH(4), .CNT_W(16)) dut (
    .Clk    (Clk),
    .ResetN (ResetN),
    .bus    (bus)
  );

  // One bus cycle: drive just after an edge, sampled by the next edge, observe 1 ns later
  task automatic cyc(input logic [5:0] s, input logic [7:0] da, input logic [3:0] wa,
                     input logic [3:0] ra, input logic [3:0] rb, input logic [2:0] alu,
                     input logic rd);
    {bus.PC_clr, bus.IR_ld, bus.PC_up, bus.D_wr, bus.RF_s, bus.RF_W_en} = s;
    bus.D_addr     = da;
    bus.RF_W_addr  = wa;
    bus.RF_Ra_addr = ra;
    bus.RF_Rb_addr = rb;
    bus.Alu_s0     = alu;
    bus.Rec_rd     = rd;
    @(posedge Clk);
    #1;
  endtask

  task automatic zero_cyc();
    cyc(S_ZERO, 8'h00, 4'h0, 4'h0, 4'h0, 3'd0, 1'b0);
  endtask

  task automatic pop_cyc();
    cyc(S_ZERO, 8'h00, 4'h0, 4'h0, 4'h0, 3'd0, 1'b1);
  endtask

  task automatic fetch_cyc();
    cyc(S_FETCH, 8'h00, 4'h0, 4'h0, 4'h0, 3'd0, 1'b0);
  endtask

  task automatic do_reset();
    ResetN = 1'b0;
    zero_cyc();
    ResetN = 1'b1;
  endtask

  task automatic alu_instr(input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] wa,
                           input logic [2:0] alu, input logic rd_on_exec);
    fetch_cyc();
    zero_cyc();
    cyc(S_WEN, 8'h00, wa, ra, rb, alu, rd_on_exec);
  endtask

  task automatic test_reset();
    ResetN = 1'b0;
    zero_cyc();
    zero_cyc();
    total++; if (bus.Rec_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.Rec_valid); end
    total++; if (bus.Rec_data !== 16'h0000) begin bad++; $display("FAIL reset_data got=%h exp=0000", bus.Rec_data); end
    total++; if (bus.Retire_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.Retire_count); end
    total++; if (bus.Halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", bus.Halted); end
    total++; if (bus.Proto_err !== 1'b0) begin bad++; $display("FAIL reset_proto got=%b exp=0", bus.Proto_err); end
    total++; if (bus.Overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", bus.Overflow); end
    // Reset asserted on the execute cycle must suppress the retire
    ResetN = 1'b1;
    fetch_cyc();
    zero_cyc();
    ResetN = 1'b0;
    cyc(S_WEN, 8'h00, 4'h4, 4'h2, 4'h3, 3'd1, 1'b0);
    ResetN = 1'b1;
    total++; if (bus.Retire_count !== 16'd0) begin bad++; $display("FAIL reset_mid_count got=%0d exp=0", bus.Retire_count); end
    total++; if (bus.Rec_valid !== 1'b0) begin bad++; $display("FAIL reset_mid_valid got=%b exp=0", bus.Rec_valid); end
  endtask

  task automatic test_add();
    do_reset();
    cyc(S_CLR, 8'h00, 4'h0, 4'h0, 4'h0, 3'd0, 1'b0);
    fetch_cyc();
    zero_cyc();
    total++; if (bus.Rec_valid !== 1'b0) begin bad++; $display("FAIL add_early_valid got=%b exp=0", bus.Rec_valid); end
    cyc(S_WEN, 8'h00, 4'h4, 4'h2, 4'h3, 3'd1, 1'b0);
    total++; if (bus.Rec_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b exp=1", bus.Rec_valid); end
    total++; if (bus.Rec_data !== 16'h3234) begin bad++; $display("FAIL add_data got=%h exp=3234", bus.Rec_data); end
    total++; if (bus.Retire_count !== 16'd1) begin bad++; $display("FAIL add_count got=%0d exp=1", bus.Retire_count); end
    pop_cyc();
    total++; if (bus.Rec_valid !== 1'b0) begin bad++; $display("FAIL add_pop_valid got=%b exp=0", bus.Rec_valid); end
    total++; if (bus.Rec_data !== 16'h0000) begin bad++; $display("FAIL add_pop_data got=%h exp=0000", bus.Rec_data); end
    pop_cyc();
    total++; if (bus.Retire_count !== 16'd1) begin bad++; $display("FAIL add_empty_pop_count got=%0d exp=1", bus.Retire_count); end
  endtask

  task automatic test_store_load();
    do_reset();
    fetch_cyc();
    zero_cyc();
    cyc(S_DWR, 8'hA7, 4'h0, 4'h5, 4'h0, 3'd0, 1'b0);
    total++; if (bus.Rec_data !== 16'h15A7) begin bad++; $display("FAIL store_data got=%h exp=15a7", bus.Rec_data); end
    fetch_cyc();
    zero_cyc();
    cyc(S_ZERO, 8'h1C, 4'h0, 4'h0, 4'h0, 3'd0, 1'b0);
    total++; if (bus.Retire_count !== 16'd1) begin bad++; $display("FAIL load_a_count got=%0d exp=1", bus.Retire_count); end
    cyc(S_LDB, 8'h1C, 4'h9, 4'h0, 4'h0, 3'd0, 1'b0);
    total++; if (bus.Retire_count !== 16'd2) begin bad++; $display("FAIL load_count got=%0d exp=2", bus.Retire_count); end
    total++; if (bus.Rec_data !== 16'h15A7) begin bad++; $display("FAIL load_head got=%h exp=15a7", bus.Rec_data); end
    pop_cyc();
    total++; if (bus.Rec_data !== 16'h21C9) begin bad++; $display("FAIL load_data got=%h exp=21c9", bus.Rec_data); end
    pop_cyc();
    total++; if (bus.Rec_valid !== 1'b0) begin bad++; $display("FAIL sl_empty got=%b exp=0", bus.Rec_valid); end
    total++; if (bus.Proto_err !== 1'b0) begin bad++; $display("FAIL sl_proto got=%b exp=0", bus.Proto_err); end
  endtask

  task automatic test_noop_sub();
    do_reset();
    fetch_cyc();
    zero_cyc();
    zero_cyc();
    total++; if (bus.Retire_count !== 16'd0) begin bad++; $display("FAIL noop_early_count got=%0d exp=0", bus.Retire_count); end
    fetch_cyc();
    total++; if (bus.Retire_count !== 16'd1) begin bad++; $display("FAIL noop_count got=%0d exp=1", bus.Retire_count); end
    total++; if (bus.Rec_valid !== 1'b1 || bus.Rec_data !== 16'h0000) begin
      bad++; $display("FAIL noop_rec got=%b/%h exp=1/0000", bus.Rec_valid, bus.Rec_data);
    end
    zero_cyc();
    cyc(S_WEN, 8'h00, 4'h0, 4'h1, 4'h1, 3'd2, 1'b0);
    total++; if (bus.Retire_count !== 16'd2) begin bad++; $display("FAIL sub_count got=%0d exp=2", bus.Retire_count); end
    pop_cyc();
    total++; if (bus.Rec_data !== 16'h4110) begin bad++; $display("FAIL sub_data got=%h exp=4110", bus.Rec_data); end
    total++; if (bus.Proto_err !== 1'b0) begin bad++; $display("FAIL ns_proto got=%b exp=0", bus.Proto_err); end
  endtask

  task automatic test_halt();
    do_reset();
    fetch_cyc();
    zero_cyc();
    zero_cyc();
    total++; if (bus.Halted !== 1'b0) begin bad++; $display("FAIL halt_early got=%b exp=0", bus.Halted); end
    zero_cyc();
    total++; if (bus.Rec_data !== 16'h5000) begin bad++; $display("FAIL halt_data got=%h exp=5000", bus.Rec_data); end
    for (int i = 0; i < 10; i++) begin
      total++; if (bus.Halted !== 1'b1) begin bad++; $display("FAIL halt_hold[%0d] got=%b exp=1", i, bus.Halted); end
      zero_cyc();
    end
    cyc(S_CLR, 8'h00, 4'h0, 4'h0, 4'h0, 3'd0, 1'b0);
    total++; if (bus.Halted !== 1'b0) begin bad++; $display("FAIL halt_clr got=%b exp=0", bus.Halted); end
    total++; if (bus.Retire_count !== 16'd1) begin bad++; $display("FAIL halt_count got=%0d exp=1", bus.Retire_count); end
    // PC_clr in the Z1 cycle abandons the instruction without a record
    fetch_cyc();
    zero_cyc();
    zero_cyc();
    cyc(S_CLR, 8'h00, 4'h0, 4'h0, 4'h0, 3'd0, 1'b0);
    total++; if (bus.Retire_count !== 16'd1 || bus.Proto_err !== 1'b0) begin
      bad++; $display("FAIL z1_clr got=%0d/%b exp=1/0", bus.Retire_count, bus.Proto_err);
    end
    alu_instr(4'h2, 4'h3, 4'h4, 3'd1, 1'b0);
    total++; if (bus.Retire_count !== 16'd2) begin bad++; $display("FAIL z1_clr_add got=%0d exp=2", bus.Retire_count); end
  endtask

  task automatic test_overflow();
    logic [15:0] exp_w [5];
    exp_w = '{16'h3123, 16'h3234, 16'h3345, 16'h3456, 16'h3567};
    do_reset();
    for (int i = 1; i <= 5; i++) alu_instr(4'(i), 4'(i + 1), 4'(i + 2), 3'd1, 1'b0);
    total++; if (bus.Overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", bus.Overflow); end
    total++; if (bus.Retire_count !== 16'd5) begin bad++; $display("FAIL ovf_count got=%0d exp=5", bus.Retire_count); end
    for (int k = 0; k < 4; k++) begin
      total++; if (bus.Rec_valid !== 1'b1 || bus.Rec_data !== exp_w[k]) begin
        bad++; $display("FAIL ovf_rd[%0d] got=%b/%h exp=1/%h", k, bus.Rec_valid, bus.Rec_data, exp_w[k]);
      end
      pop_cyc();
    end
    total++; if (bus.Rec_valid !== 1'b0) begin bad++; $display("FAIL ovf_drained got=%b exp=0", bus.Rec_valid); end
    do_reset();
    for (int i = 1; i <= 4; i++) alu_instr(4'(i), 4'(i + 1), 4'(i + 2), 3'd1, 1'b0);
    alu_instr(4'h5, 4'h6, 4'h7, 3'd1, 1'b1);
    total++; if (bus.Overflow !== 1'b0) begin bad++; $display("FAIL popfull_flag got=%b exp=0", bus.Overflow); end
    total++; if (bus.Retire_count !== 16'd5) begin bad++; $display("FAIL popfull_count got=%0d exp=5", bus.Retire_count); end
    for (int k = 1; k < 5; k++) begin
      total++; if (bus.Rec_valid !== 1'b1 || bus.Rec_data !== exp_w[k]) begin
        bad++; $display("FAIL popfull_rd[%0d] got=%b/%h exp=1/%h", k, bus.Rec_valid, bus.Rec_data, exp_w[k]);
      end
      pop_cyc();
    end
    total++; if (bus.Rec_valid !== 1'b0) begin bad++; $display("FAIL popfull_drained got=%b exp=0", bus.Rec_valid); end
  endtask

  task automatic test_proto_err();
    do_reset();
    fetch_cyc();
    cyc(S_DWR, 8'h55, 4'h0, 4'h1, 4'h0, 3'd0, 1'b0);
    total++; if (bus.Proto_err !== 1'b1) begin bad++; $display("FAIL proto_set got=%b exp=1", bus.Proto_err); end
    zero_cyc();
    total++; if (bus.Rec_valid !== 1'b0 || bus.Retire_count !== 16'd0) begin
      bad++; $display("FAIL proto_norec got=%b/%0d exp=0/0", bus.Rec_valid, bus.Retire_count);
    end
    cyc(S_CLR, 8'h00, 4'h0, 4'h0, 4'h0, 3'd0, 1'b0);
    alu_instr(4'h2, 4'h3, 4'h4, 3'd1, 1'b0);
    total++; if (bus.Retire_count !== 16'd1 || bus.Rec_data !== 16'h3234) begin
      bad++; $display("FAIL proto_add got=%0d/%h exp=1/3234", bus.Retire_count, bus.Rec_data);
    end
    total++; if (bus.Proto_err !== 1'b1) begin bad++; $display("FAIL proto_sticky got=%b exp=1", bus.Proto_err); end
    do_reset();
    total++; if (bus.Proto_err !== 1'b0 || bus.Rec_valid !== 1'b0 || bus.Retire_count !== 16'd0 || bus.Rec_data !== 16'h0000) begin
      bad++; $display("FAIL proto_reset got=%b/%b/%0d/%h exp=0/0/0/0000",
                      bus.Proto_err, bus.Rec_valid, bus.Retire_count, bus.Rec_data);
    end
  endtask

  initial begin
    ResetN = 1'b0;
    test_reset();
    test_add();
    test_store_load();
    test_noop_sub();
    test_halt();
    test_overflow();
    test_proto_err();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_retire_monitor.md
# instr_retire_monitor

- Passive observer on the control-unit output bus of the TCES330 processor.
- Each cycle it samples the control strobes and addresses, tracks the Init/Fetch/Decode/Execute sequence, and re-encodes each retired instruction into its 16-bit IR word.
- It is the decode-side inverse of the control unit: IR word in there, IR word back out here.
- Reconstructed words go into a small FIFO that the testbench or a debug port drains, alongside a retire counter and sticky protocol-error and overflow flags.

## Interface
- DEPTH, 4: record FIFO entries (power of two, ≥2)
- CNT_W, 16: retire counter width
- Clk  in  1  clock, all logic on rising edge
- ResetN  in  1  synchronous, active-low reset
- PC_clr, IR_ld, PC_up, D_wr, RF_s, RF_W_en  in  1 each  observed control strobes
- D_addr  in  8  observed data-memory address
- RF_W_addr, RF_Ra_addr, RF_Rb_addr  in  4 each  observed register-file addresses
- Alu_s0  in  3  observed ALU select
- Rec_rd  in  1  pop FIFO head; ignored when empty
- Rec_valid  out  1  FIFO not empty
- Rec_data  out  16  FIFO head word (opcode in [15:12])
- Retire_count  out  CNT_W  instructions retired, wraps modulo 2^CNT_W
- Halted  out  1  Halt retired, waiting for PC_clr
- Proto_err  out  1  sticky, illegal strobe sequence seen
- Overflow  out  1  sticky, record dropped because FIFO full

## Operation
- Definitions:
  - ACT = PC_clr | IR_ld | PC_up | D_wr | RF_s | RF_W_en.
  - ZERO = !ACT.
  - FETCH = IR_ld & PC_up & !PC_clr & !D_wr & !RF_s & !RF_W_en.
- All decisions use inputs sampled at the current rising edge, combined with the current state.
- States and transitions:
  - IDLE:
    - PC_clr or ZERO → IDLE.
    - FETCH → DEC.
    - any other ACT → ERR.
  - DEC (decode cycle):
    - ZERO → EXE.
    - otherwise → ERR.
  - EXE:
    - D_wr & !RF_W_en & !RF_s → retire Store {4'h1, RF_Ra_addr, D_addr}, → IDLE.
    - RF_W_en & !RF_s & !D_wr & Alu_s0==1 → retire Add {4'h3, RF_Ra_addr, RF_Rb_addr, RF_W_addr}, → IDLE.
    - Same strobe pattern with Alu_s0==2 → retire Sub {4'h4, RF_Ra_addr, RF_Rb_addr, RF_W_addr}, → IDLE.
    - ZERO → Z1.
    - otherwise → ERR.
  - Z1 (Noop, Load_A, or first Halt cycle):
    - FETCH → retire Noop 16'h0000, → DEC.
    - RF_s & RF_W_en & !D_wr → retire Load {4'h2, D_addr, RF_W_addr}, → IDLE.
    - ZERO → retire Halt 16'h5000, → HALTED.
    - PC_clr → IDLE, no retire.
    - otherwise → ERR.
  - HALTED:
    - ZERO → HALTED.
    - PC_clr → IDLE.
    - otherwise → ERR.
  - ERR:
    - PC_clr → IDLE.
    - otherwise → ERR.
- Outputs by state:
  - Halted = 1 exactly while in HALTED.
  - Proto_err sets on any transition into ERR and clears only on reset.
- Retire action:
  - Retire_count increments by 1.
  - The word is pushed into the FIFO.
- FIFO full:
  - Full with no pop → the word is dropped and Overflow sets. Retire_count still increments.
  - Full with a simultaneous pop → pop and push both occur, no overflow.
- Pop:
  - Rec_rd with Rec_valid removes the head.
  - Rec_rd when empty has no effect.

## Timing
- Reset (ResetN low at a rising edge):
  - state = IDLE.
  - FIFO empty, so Rec_valid = 0 and Rec_data = 0.
  - Retire_count = 0, Halted = 0, Proto_err = 0, Overflow = 0.
  - Reset wins over every other event, including a retire or pop in the same cycle.
- Retire latency:
  - The FIFO and counter update at the edge that samples the deciding cycle.
  - Rec_valid and Retire_count reflect the retire immediately after that edge.
  - Store, Add, Sub: edge ending the execute cycle, i.e. fetch + 3 edges.
  - Load: edge ending Load_B, i.e. fetch + 4.
  - Noop: edge ending the following fetch, i.e. fetch + 4.
  - Halt: edge ending the second zero cycle after decode, i.e. fetch + 4.
- Rec_data is the registered head word.
  - After a pop edge it shows the next entry.
  - Empty FIFO → Rec_data holds 0.
- Reset mid-instruction: all partial tracking is discarded, nothing is retired.
- PC_clr mid-instruction (in DEC): ERR. In EXE: ERR. In Z1: IDLE with no retire.

## Test plan
- Reset, then PC_clr 1 cycle, then the Add sequence with Ra=2, Rb=3, W=4, Alu_s0=1 → Rec_data = 16'h3234, Retire_count = 1, exactly 3 edges after the fetch edge.
- Store (Ra=5, D_addr=8'hA7), then Load (D_addr=8'h1C, W=9) → FIFO pops 16'h15A7, then 16'h21C9; Proto_err = 0.
- Noop followed by a Sub (Ra=1, Rb=1, W=0, Alu_s0=2) → records 16'h0000, then 16'h4110; Noop is retired on the Sub's fetch edge.
- Halt sequence, then zero cycles for 10 clocks, then PC_clr → one record 16'h5000, Halted = 1 for 10+ cycles, then 0 after PC_clr; Retire_count = 1.
- Five Adds with no Rec_rd (DEPTH=4) → Overflow = 1, Retire_count = 5, only the first four words are readable. Repeat with a pop on the fifth retire edge → Overflow stays 0.
- D_wr asserted in the decode cycle → Proto_err = 1, no record. Then PC_clr and a valid Add → the Add is retired and Proto_err stays 1. ResetN low → everything returns to zero.
